// File: rtl/bp_btb_counter_ras.sv
// BTB + saturating direction counters + optional return-address stack.
// Optional RAS enabled by defining BP_RAS_EN.
module bp_btb_counter_ras #(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 32,
    parameter int CNT_BITS  = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            hit_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_pc_o,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [1:0]      ex_type_i,
    input  logic            ex_call_i,
    input  logic            ex_taken_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_pc_i,
    output logic [1:0]      mispredict_o,
    output logic [XLEN-1:0] correct_pc_o
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_BR   = 2'b01;
    localparam logic [1:0] T_RET  = 2'b11;

    localparam logic [CNT_BITS-1:0] CMAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CWEAK = CNT_BITS'(1) << (CNT_BITS - 1);

    logic                valid_q [ENTRIES];
    logic [TAGW-1:0]     tag_q   [ENTRIES];
    logic [XLEN-1:0]     tgt_q   [ENTRIES];
    logic [1:0]          typ_q   [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q   [ENTRIES];

    logic [IDX-1:0]      f_idx, e_idx;
    logic [TAGW-1:0]     f_tag, e_tag;
    logic                act, taken, e_hit;
    logic [XLEN-1:0]     f_tgt;
    logic [CNT_BITS-1:0] cnt_d;

    assign f_idx = pc_i[IDX+1:2];
    assign f_tag = pc_i[XLEN-1:IDX+2];
    assign e_idx = ex_pc_i[IDX+1:2];
    assign e_tag = ex_pc_i[XLEN-1:IDX+2];

    assign act   = ex_valid_i && (ex_type_i != T_NONE) && !rst_i;
    assign taken = (ex_type_i == T_BR) ? ex_taken_i : (ex_type_i != T_NONE);
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

`ifdef BP_RAS_EN
    localparam int RIDX = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [RIDX-1:0] ras_ptr_q, ras_ptr_d, ras_wr_idx;
    logic [RIDX:0]   ras_cnt_q, ras_cnt_d;
    logic            ras_push;

    // Pop first, then push at the post-pop pointer (call+ret replaces top).
    always_comb begin
        ras_ptr_d  = ras_ptr_q;
        ras_cnt_d  = ras_cnt_q;
        ras_push   = act && ex_call_i;
        if (act && (ex_type_i == T_RET) && (ras_cnt_q != '0)) begin
            ras_ptr_d = ras_ptr_q - 1'b1;
            ras_cnt_d = ras_cnt_q - 1'b1;
        end
        ras_wr_idx = ras_ptr_d;
        if (ras_push) begin
            ras_ptr_d = ras_ptr_d + 1'b1;
            if (ras_cnt_d != (RIDX+1)'(RAS_DEPTH))
                ras_cnt_d = ras_cnt_d + 1'b1;
        end
    end

    // Stack storage, pointer and occupancy; oldest slot overwritten when full.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            if (ras_push)
                ras_q[ras_wr_idx] <= ex_pc_i + XLEN'(4);
        end
    end

    // RET entries predict from the stack top when it holds anything.
    always_comb begin
        f_tgt = tgt_q[f_idx];
        if ((typ_q[f_idx] == T_RET) && (ras_cnt_q != '0))
            f_tgt = ras_q[ras_ptr_q - 1'b1];
    end
`else
    logic unused_call;
    assign unused_call = ex_call_i;
    assign f_tgt       = tgt_q[f_idx];
`endif

    // Combinational fetch lookup, forced to a miss while in reset.
    always_comb begin
        hit_o        = !rst_i && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken_o = hit_o &&
                       (cnt_q[f_idx][CNT_BITS-1] || (typ_q[f_idx] != T_BR));
        pred_pc_o    = pred_taken_o ? f_tgt : pc_i + XLEN'(4);
    end

    // Misprediction class and redirect target for the execute instruction.
    always_comb begin
        mispredict_o = 2'b00;
        correct_pc_o = taken ? ex_target_i : ex_pc_i + XLEN'(4);
        if (act) begin
            if (ex_pred_taken_i && !taken)
                mispredict_o = 2'b01;
            else if (!ex_pred_taken_i && taken)
                mispredict_o = 2'b10;
            else if (ex_pred_taken_i && taken && (ex_pred_pc_i != ex_target_i))
                mispredict_o = 2'b11;
        end
    end

    // Next counter value for a hit: saturating for BR, pinned high otherwise.
    always_comb begin
        cnt_d = cnt_q[e_idx];
        if (ex_type_i != T_BR)
            cnt_d = CMAX;
        else if (ex_taken_i && (cnt_q[e_idx] != CMAX))
            cnt_d = cnt_q[e_idx] + 1'b1;
        else if (!ex_taken_i && (cnt_q[e_idx] != '0))
            cnt_d = cnt_q[e_idx] - 1'b1;
    end

    // Table update: refresh on hit, allocate on taken miss.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CWEAK;
            end
        end else if (act) begin
            if (e_hit) begin
                tgt_q[e_idx] <= ex_target_i;
                typ_q[e_idx] <= ex_type_i;
                cnt_q[e_idx] <= cnt_d;
            end else if (taken) begin
                valid_q[e_idx] <= 1'b1;
                tag_q[e_idx]   <= e_tag;
                tgt_q[e_idx]   <= ex_target_i;
                typ_q[e_idx]   <= ex_type_i;
                cnt_q[e_idx]   <= CWEAK;
            end
        end
    end

endmodule

// File: tb/tb_bp_btb_counter_ras.sv
// Directed self-checking bench for bp_btb_counter_ras.
// RAS scenario runs only when BP_RAS_EN is defined.
module tb_bp_btb_counter_ras;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        hit, ptk;
    logic [31:0] ppc;
    logic        exv, exc, ext, exptk;
    logic [31:0] expc, extgt, exppc;
    logic [1:0]  exty;
    logic [1:0]  mis;
    logic [31:0] cpc;

    int n_run  = 0;
    int n_fail = 0;

    bp_btb_counter_ras dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pc_i           (pc),
        .hit_o          (hit),
        .pred_taken_o   (ptk),
        .pred_pc_o      (ppc),
        .ex_valid_i     (exv),
        .ex_pc_i        (expc),
        .ex_type_i      (exty),
        .ex_call_i      (exc),
        .ex_taken_i     (ext),
        .ex_target_i    (extgt),
        .ex_pred_taken_i(exptk),
        .ex_pred_pc_i   (exppc),
        .mispredict_o   (mis),
        .correct_pc_o   (cpc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        exv = 1'b0;
    endtask

    task automatic look(input logic [31:0] a);
        pc = a;
        #1;
    endtask

    task automatic res(input logic [31:0] a, input logic [1:0] ty,
                       input logic c, input logic tk, input logic [31:0] tg,
                       input logic pt, input logic [31:0] pp);
        exv = 1'b1; expc = a; exty = ty; exc = c; ext = tk;
        extgt = tg; exptk = pt; exppc = pp;
        #1;
    endtask

    initial begin
        rst = 1'b1; exv = 1'b0; pc = 32'h0; expc = 0; exty = 0;
        exc = 0; ext = 0; extgt = 0; exptk = 0; exppc = 0;
        step();
        // resolution during reset must be discarded
        look(32'h200);
        res(32'h200, 2'b10, 1'b0, 1'b1, 32'h300, 1'b0, 32'h204);
        chk("rst_hit", hit, 0);
        chk("rst_ptk", ptk, 0);
        chk("rst_ppc", ppc, 32'h204);
        chk("rst_mis", mis, 0);
        step();
        rst = 1'b0;
        look(32'h200);
        chk("rst_drop", hit, 0);
        look(32'h100);
        chk("init_hit", hit, 0);
        chk("init_ppc", ppc, 32'h104);

        // BR 0x100 taken -> 0x180, allocate weak taken
        res(32'h100, 2'b01, 0, 1, 32'h180, 0, 32'h104);
        chk("br_alloc_mis", mis, 2'b10);
        chk("br_alloc_cpc", cpc, 32'h180);
        step();
        look(32'h100);
        chk("br_hit", hit, 1);
        chk("br_ptk", ptk, 1);
        chk("br_ppc", ppc, 32'h180);
        res(32'h100, 2'b01, 0, 0, 32'h180, 1, 32'h180);
        chk("nt1_mis", mis, 2'b01);
        chk("nt1_cpc", cpc, 32'h104);
        step();
        look(32'h100);
        chk("nt1_ptk", ptk, 0);
        chk("nt1_ppc", ppc, 32'h104);
        res(32'h100, 2'b01, 0, 0, 32'h180, 0, 32'h104);
        chk("nt2_mis", mis, 2'b00);
        step();
        look(32'h100);
        chk("nt2_ptk", ptk, 0);

        // counter at 0: one taken -> 1 (still not taken)
        res(32'h100, 2'b01, 0, 1, 32'h180, 0, 32'h104);
        step();
        look(32'h100);
        chk("c1_ptk", ptk, 0);
        for (int i = 0; i < 4; i++) begin
            res(32'h100, 2'b01, 0, 1, 32'h180, ptk, ppc);
            step();
        end
        res(32'h100, 2'b01, 0, 0, 32'h180, 1, 32'h180);
        step();
        look(32'h100);
        chk("sat_ptk", ptk, 1);
        res(32'h100, 2'b01, 0, 0, 32'h180, 1, 32'h180);
        step();
        look(32'h100);
        chk("sat2_ptk", ptk, 0);

        // conflict: 0x180 evicts 0x100
        res(32'h180, 2'b01, 0, 1, 32'h1c0, 0, 32'h184);
        step();
        look(32'h100);
        chk("conf_miss", hit, 0);
        look(32'h180);
        chk("conf_hit", hit, 1);
        chk("conf_ppc", ppc, 32'h1c0);

        // JALR target change
        res(32'h200, 2'b10, 0, 0, 32'h300, 0, 32'h204);
        chk("jmp_mis", mis, 2'b10);
        step();
        look(32'h200);
        chk("jmp_ppc", ppc, 32'h300);
        res(32'h200, 2'b10, 0, 0, 32'h340, 1, 32'h300);
        chk("jmp_mis11", mis, 2'b11);
        chk("jmp_cpc", cpc, 32'h340);
        step();
        look(32'h200);
        chk("jmp_new", ppc, 32'h340);

        // not-taken BR miss, and invalid slot: no allocation
        res(32'h300, 2'b01, 0, 0, 32'h380, 0, 32'h304);
        chk("ntmiss_mis", mis, 0);
        step();
        look(32'h300);
        chk("ntmiss_hit", hit, 0);
        res(32'h500, 2'b01, 0, 1, 32'h580, 0, 32'h504);
        exv = 1'b0;
        #1;
        chk("inv_mis", mis, 0);
        step();
        look(32'h500);
        chk("inv_hit", hit, 0);

`ifdef BP_RAS_EN
        res(32'h400, 2'b11, 0, 1, 32'h600, 0, 32'h404);
        step();
        for (int i = 1; i <= 5; i++) begin
            res(32'(i * 16), 2'b10, 1, 1, 32'h800, 0, 32'(i * 16 + 4));
            step();
        end
        for (int i = 0; i < 5; i++) begin
            look(32'h400);
            chk("ras_pop", ppc, (i < 4) ? 32'(32'h54 - i * 16) : 32'h600);
            res(32'h400, 2'b11, 0, 1, 32'h600, 1, ppc);
            step();
        end
        // call+ret together replaces the top
        res(32'h10, 2'b10, 1, 1, 32'h800, 1, 32'h800);
        step();
        res(32'h400, 2'b11, 1, 1, 32'h600, 1, 32'h14);
        step();
        look(32'h400);
        chk("ras_swap", ppc, 32'h404);
        res(32'h400, 2'b11, 0, 1, 32'h600, 1, 32'h404);
        step();
        look(32'h400);
        chk("ras_empty", ppc, 32'h600);
`else
        // RET behaves as JMP, call flag ignored
        res(32'h400, 2'b11, 1, 1, 32'h600, 0, 32'h404);
        chk("ret_mis", mis, 2'b10);
        step();
        look(32'h400);
        chk("ret_hit", hit, 1);
        chk("ret_ppc", ppc, 32'h600);
`endif

        // reset mid-resolution: update dropped, table cleared
        rst = 1'b1;
        res(32'h700, 2'b10, 0, 1, 32'h780, 0, 32'h704);
        look(32'h180);
        chk("mrst_mis", mis, 0);
        chk("mrst_hit", hit, 0);
        step();
        rst = 1'b0;
        look(32'h180);
        chk("mrst_clr", hit, 0);
        look(32'h700);
        chk("mrst_drop", hit, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_btb_counter_ras.md
# bp_btb_counter_ras

Parametrised dynamic branch predictor for the RV32I pipeline. It sits beside the fetch stage and resolves in execute. It combines:
- a direct-mapped branch target buffer (BTB) of configurable depth, with full tags;
- per-entry saturating direction counters of configurable width;
- a target-mismatch misprediction class;
- an optional return-address stack (RAS).

Fetch performs a combinational lookup on `pc_i`; the execute stage reports the resolved outcome, which updates the tables at the next clock edge.

## Interface
Parameters:
- `XLEN`, 32, address/data width
- `ENTRIES`, 32, BTB/counter entries; power of two, ≥2; `IDX = log2(ENTRIES)`
- `CNT_BITS`, 2, direction counter width, ≥1
- `RAS_DEPTH`, 4, return stack entries; power of two, ≥2; used only with `BP_RAS_EN`

Ports:
- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `pc_i`  in  XLEN  fetch PC
- `hit_o`  out  1  BTB hit (valid and tag match)
- `pred_taken_o`  out  1  predict redirect: `hit_o` and (counter MSB = 1, or entry type ≠ BR)
- `pred_pc_o`  out  XLEN  predicted next PC: target if `pred_taken_o`, else `pc_i+4`
- `ex_valid_i`  in  1  execute stage holds a valid instruction
- `ex_pc_i`  in  XLEN  PC of the execute instruction
- `ex_type_i`  in  2  00 non-control, 01 BR (conditional), 10 JMP (JAL/JALR), 11 RET (JALR, rs1 ∈ {x1,x5}, rd = x0)
- `ex_call_i`  in  1  JAL/JALR with rd ∈ {x1,x5}
- `ex_taken_i`  in  1  resolved taken; ignored for types 10/11, which are always taken
- `ex_target_i`  in  XLEN  resolved target (ALU result)
- `ex_pred_taken_i`  in  1  `pred_taken_o` carried down the pipe with this instruction
- `ex_pred_pc_i`  in  XLEN  `pred_pc_o` carried down the pipe with this instruction
- `mispredict_o`  out  2  00 ok; 01 predicted taken, not taken; 10 predicted not taken, taken; 11 taken with wrong target
- `correct_pc_o`  out  XLEN  redirect PC: `ex_target_i` if taken, else `ex_pc_i+4`

## Operation
- Index = `pc[IDX+1:2]`; tag = `pc[XLEN-1:IDX+2]`.
- Each entry holds: valid, tag, target, type (2 bits), counter (`CNT_BITS` bits).
- Lookup is purely combinational. The lookup reads the table state before any same-cycle update; there is no write-through bypass.
- Resolution is active only when `ex_valid_i` = 1 and `ex_type_i` ≠ 00. Otherwise `mispredict_o` = 00 and no state changes.
- Misprediction class:
  - 01 if predicted taken and not taken;
  - 10 if predicted not taken and taken;
  - 11 if predicted taken, taken, and `ex_pred_pc_i` ≠ `ex_target_i`.
- Allocation on a miss:
  - only when taken (types 10/11 are always taken);
  - writes valid = 1, tag, target, type, and counter = `2^(CNT_BITS-1)` (weak taken);
  - replaces any conflicting entry.
- Update on a hit:
  - target and type are rewritten;
  - BR counter increments on taken, decrements on not taken, saturating at 0 and at `2^CNT_BITS-1`;
  - type 10/11 counter is held at maximum.
- A not-taken BR that misses the BTB does not allocate.

## Timing
- Lookup to outputs: 0 cycles (combinational).
- An update resolved in cycle N is visible to lookup in cycle N+1.
- `mispredict_o` and `correct_pc_o` are combinational from the ex inputs in the same cycle.
- Reset:
  - all valid bits cleared;
  - all counters set to `2^(CNT_BITS-1)`;
  - RAS pointer = 0 and count = 0;
  - while `rst_i` = 1: `hit_o` = 0, `pred_taken_o` = 0, `pred_pc_o` = `pc_i+4`, `mispredict_o` = 00, no table writes.
- Reset asserted mid-resolution: the update is discarded.

## Configuration
- `BP_RAS_EN` defined:
  - On resolution of a call (`ex_call_i`), push `ex_pc_i+4`.
  - On resolution of RET, pop.
  - Call and RET together (RET type with `ex_call_i` = 1): pop then push, so the top is replaced and the count is unchanged.
  - Push when full: circular overwrite of the oldest entry; the count stays at `RAS_DEPTH`.
  - Pop when empty: no change.
  - Fetch hit on a RET-type entry with a non-empty RAS: `pred_pc_o` = RAS top. With an empty RAS, the BTB target is used.
  - Class 11 compares against the RAS-based prediction.
- `BP_RAS_EN` undefined:
  - no RAS storage;
  - RET is treated exactly as JMP;
  - `ex_call_i` is ignored;
  - ports are unchanged.

## Test plan
- Reset, then `pc_i`=0x100 → `hit_o`=0, `pred_pc_o`=0x104.
- BR at 0x100, taken to 0x180, counter at weak taken. Next cycle `pc_i`=0x100 → `hit_o`=1, `pred_pc_o`=0x180. Resolve it not taken twice → the second lookup after that gives `pred_taken_o`=0; the resolution reports 01 first, then 00.
- `CNT_BITS`=2, saturation: taken ×5, then a single not-taken → `pred_taken_o` remains 1 (counter 3→2).
- Conflict: 0x100 and 0x180 share an index when `ENTRIES`=32. Allocate 0x100, then a taken branch at 0x180 → lookup 0x100 misses.
- JALR at 0x200, predicted 0x300, resolved 0x340 → `mispredict_o`=11, `correct_pc_o`=0x340. Next lookup gives `pred_pc_o`=0x340.
- `BP_RAS_EN`, `RAS_DEPTH`=4: calls at 0x10, 0x20, 0x30, 0x40, 0x50 (overflow), then 5 RETs → predictions 0x54, 0x44, 0x34, 0x24, then BTB target once empty.
